// File: rtl/frog_status.sv
// Frogger hazard / scoring / lives controller. Evaluates the frog box against
// car and log boxes once per frame and sequences death, home and respawn.

module frog_status_box (
  input  logic [10:0] ax,
  input  logic [10:0] ay,
  input  logic [10:0] aw,
  input  logic [10:0] ah,
  input  logic [10:0] bx,
  input  logic [10:0] by,
  input  logic [10:0] bw,
  input  logic [10:0] bh,
  output logic        hit
);
  // 12-bit sums so a box near the right/bottom edge cannot wrap.
  logic [11:0] a_xe, a_ye, b_xe, b_ye;
  assign a_xe = {1'b0, ax} + {1'b0, aw};
  assign a_ye = {1'b0, ay} + {1'b0, ah};
  assign b_xe = {1'b0, bx} + {1'b0, bw};
  assign b_ye = {1'b0, by} + {1'b0, bh};
  assign hit  = ({1'b0, ax} < b_xe) && ({1'b0, bx} < a_xe) &&
                ({1'b0, ay} < b_ye) && ({1'b0, by} < a_ye);
endmodule

module frog_status #(
  parameter int NUM_CARS     = 4,
  parameter int NUM_LOGS     = 4,
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 30,
  parameter int FROG_Y_START = 440,
  parameter int HOME_Y       = 0,
  parameter int WATER_Y_MIN  = 40,
  parameter int WATER_Y_MAX  = 200
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [10:0]             FrogX,
  input  logic [10:0]             FrogY,
  input  logic [10:0]             Frog_Width,
  input  logic [10:0]             Frog_Height,
  input  logic [11*NUM_CARS-1:0]  CarX,
  input  logic [11*NUM_CARS-1:0]  CarY,
  input  logic [10:0]             Car_Width,
  input  logic [10:0]             Car_Height,
  input  logic [11*NUM_LOGS-1:0]  LogX,
  input  logic [11*NUM_LOGS-1:0]  LogY,
  input  logic [10:0]             Log_Width,
  input  logic [10:0]             Log_Height,
  output logic                    Frog_Respawn,
  output logic                    Dying,
  output logic [2:0]              Lives,
  output logic [15:0]             Score,
  output logic [2:0]              Homes,
  output logic                    Level_Up,
  output logic                    Game_Over
);
  localparam int CW = (DEATH_FRAMES < 2) ? 1 : $clog2(DEATH_FRAMES);
  localparam logic [10:0] Y_START = 11'(FROG_Y_START);
  localparam logic [10:0] Y_HOME  = 11'(HOME_Y);
  localparam logic [10:0] W_MIN   = 11'(WATER_Y_MIN);
  localparam logic [10:0] W_MAX   = 11'(WATER_Y_MAX);

  typedef enum logic [2:0] {ALIVE, DYING, HOME, RESPAWN, OVER} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [10:0]   best_q;
  logic [2:0]    lives_q, homes_q;
  logic [15:0]   score_q;
  logic          respawn_q, dying_q, level_q, over_q;

  logic [NUM_CARS-1:0] car_ov;
  logic [NUM_LOGS-1:0] log_ov;

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    frog_status_box u_box (
      .ax(FrogX), .ay(FrogY), .aw(Frog_Width), .ah(Frog_Height),
      .bx(CarX[11*g +: 11]), .by(CarY[11*g +: 11]),
      .bw(Car_Width), .bh(Car_Height), .hit(car_ov[g])
    );
  end

  for (genvar g = 0; g < NUM_LOGS; g++) begin : g_log
    frog_status_box u_box (
      .ax(FrogX), .ay(FrogY), .aw(Frog_Width), .ah(Frog_Height),
      .bx(LogX[11*g +: 11]), .by(LogY[11*g +: 11]),
      .bw(Log_Width), .bh(Log_Height), .hit(log_ov[g])
    );
  end

  logic frame_ok, car_hit, water_hit, at_home;
  assign frame_ok  = (FrogX < 11'd800) && (FrogY < 11'd800);
  assign car_hit   = |car_ov;
  assign water_hit = (FrogY >= W_MIN) && (FrogY < W_MAX) && !(|log_ov);
  assign at_home   = (FrogY == Y_HOME);

  logic [16:0] sum10_d, sum50_d;
  logic [15:0] score10_d, score50_d;
  assign sum10_d   = {1'b0, score_q} + 17'd10;
  assign sum50_d   = {1'b0, score_q} + 17'd50;
  assign score10_d = sum10_d[16] ? 16'hFFFF : sum10_d[15:0];
  assign score50_d = sum50_d[16] ? 16'hFFFF : sum50_d[15:0];

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ALIVE;
      cnt_q     <= '0;
      best_q    <= Y_START;
      lives_q   <= 3'(LIVES_INIT);
      score_q   <= '0;
      homes_q   <= '0;
      respawn_q <= 1'b0;
      dying_q   <= 1'b0;
      level_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      level_q <= 1'b0;
      case (state_q)
        ALIVE: if (frame_ok) begin
          if (at_home) begin
            state_q <= HOME;
            score_q <= score50_d;
            if (homes_q == 3'd4) begin
              homes_q <= '0;
              level_q <= 1'b1;
            end else begin
              homes_q <= homes_q + 3'd1;
            end
          end else if (car_hit || water_hit) begin
            state_q <= DYING;
            dying_q <= 1'b1;
            cnt_q   <= CW'(DEATH_FRAMES - 1);
          end else if (FrogY < best_q) begin
            best_q  <= FrogY;
            score_q <= score10_d;
          end
        end
        DYING: begin
          if (cnt_q == '0) begin
            dying_q <= 1'b0;
            if (lives_q == 3'd1) begin
              lives_q <= '0;
              over_q  <= 1'b1;
              state_q <= OVER;
            end else begin
              lives_q   <= lives_q - 3'd1;
              state_q   <= RESPAWN;
              respawn_q <= 1'b1;
              cnt_q     <= CW'(1);
              best_q    <= Y_START;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOME: begin
          state_q   <= RESPAWN;
          respawn_q <= 1'b1;
          cnt_q     <= CW'(1);
          best_q    <= Y_START;
        end
        // Second respawn frame lets the mover settle before evaluating again.
        RESPAWN: begin
          if (cnt_q == '0) begin
            respawn_q <= 1'b0;
            state_q   <= ALIVE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        OVER:    ;
        default: state_q <= ALIVE;
      endcase
    end
  end

  assign Frog_Respawn = respawn_q;
  assign Dying        = dying_q;
  assign Lives        = lives_q;
  assign Score        = score_q;
  assign Homes        = homes_q;
  assign Level_Up     = level_q;
  assign Game_Over    = over_q;
endmodule

// File: tb/tb_frog_status.sv
// Scoreboard bench for frog_status: a frame-level model predicts every
// frame's outputs; a monitor pops and compares them after each edge.

module tb_frog_status;
  localparam int NC = 4, NL = 4, DF = 30, YSTART = 440;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [10:0] FrogX, FrogY, Frog_Width, Frog_Height;
  logic [10:0] Car_Width, Car_Height, Log_Width, Log_Height;
  logic [11*NC-1:0] CarX, CarY;
  logic [11*NL-1:0] LogX, LogY;
  logic        Frog_Respawn, Dying, Level_Up, Game_Over;
  logic [2:0]  Lives, Homes;
  logic [15:0] Score;

  always #5 frame_clk = ~frame_clk;

  frog_status dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .FrogX(FrogX), .FrogY(FrogY), .Frog_Width(Frog_Width), .Frog_Height(Frog_Height),
    .CarX(CarX), .CarY(CarY), .Car_Width(Car_Width), .Car_Height(Car_Height),
    .LogX(LogX), .LogY(LogY), .Log_Width(Log_Width), .Log_Height(Log_Height),
    .Frog_Respawn(Frog_Respawn), .Dying(Dying), .Lives(Lives), .Score(Score),
    .Homes(Homes), .Level_Up(Level_Up), .Game_Over(Game_Over)
  );

  typedef struct packed {
    logic        rsp;
    logic        dy;
    logic [2:0]  lives;
    logic [15:0] score;
    logic [2:0]  homes;
    logic        lvl;
    logic        ovr;
  } exp_t;

  exp_t q[$];
  int n_tests = 0, n_fail = 0;

  // Frame-level model: frames remaining in each phase, plain integers.
  int m_lives, m_score, m_homes, m_best;
  int m_dleft, m_rleft;
  bit m_over, m_homef, m_lvl;

  task automatic model_reset();
    m_lives = 3; m_score = 0; m_homes = 0; m_best = YSTART;
    m_dleft = 0; m_rleft = 0; m_over = 0; m_homef = 0; m_lvl = 0;
  endtask

  function automatic bit ovl(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  function automatic int sat(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step();
    int fx, fy, fw, fh;
    bit car, on_log, water;
    fx = int'(FrogX); fy = int'(FrogY); fw = int'(Frog_Width); fh = int'(Frog_Height);
    if (m_over) return;
    if (m_homef) begin
      m_homef = 0; m_lvl = 0; m_rleft = 2; m_best = YSTART;
      return;
    end
    if (m_rleft > 0) begin m_rleft--; return; end
    if (m_dleft > 0) begin
      m_dleft--;
      if (m_dleft == 0) begin
        m_lives--;
        if (m_lives == 0) m_over = 1;
        else begin m_rleft = 2; m_best = YSTART; end
      end
      return;
    end
    if (fx >= 800 || fy >= 800) return;
    car = 0; on_log = 0;
    for (int i = 0; i < NC; i++)
      if (ovl(fx, fy, fw, fh, int'(CarX[11*i +: 11]), int'(CarY[11*i +: 11]),
              int'(Car_Width), int'(Car_Height))) car = 1;
    for (int i = 0; i < NL; i++)
      if (ovl(fx, fy, fw, fh, int'(LogX[11*i +: 11]), int'(LogY[11*i +: 11]),
              int'(Log_Width), int'(Log_Height))) on_log = 1;
    water = (fy >= 40) && (fy < 200) && !on_log;
    if (fy == 0) begin
      m_score = sat(m_score + 50);
      m_homef = 1;
      if (m_homes == 4) begin m_homes = 0; m_lvl = 1; end
      else m_homes++;
    end else if (car || water) begin
      m_dleft = DF;
    end else if (fy < m_best) begin
      m_best = fy;
      m_score = sat(m_score + 10);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rsp = (m_rleft > 0); e.dy = (m_dleft > 0);
    e.lives = 3'(m_lives); e.score = 16'(m_score); e.homes = 3'(m_homes);
    e.lvl = m_lvl; e.ovr = m_over;
    return e;
  endfunction

  task automatic check(string nm, exp_t e);
    exp_t a;
    a = '{Frog_Respawn, Dying, Lives, Score, Homes, Level_Up, Game_Over};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got rsp=%0b dy=%0b lives=%0d score=%0d homes=%0d lvl=%0b over=%0b; want rsp=%0b dy=%0b lives=%0d score=%0d homes=%0d lvl=%0b over=%0b",
               nm, $time, a.rsp, a.dy, a.lives, a.score, a.homes, a.lvl, a.ovr,
               e.rsp, e.dy, e.lives, e.score, e.homes, e.lvl, e.ovr);
    end
  endtask

  // Monitor: every frame edge produces one output set to compare.
  always @(posedge frame_clk) begin
    #2;
    if (Reset && q.size() > 0) check("frame", q.pop_front());
  end

  task automatic frame();
    @(posedge frame_clk);
    model_step();
    q.push_back(model_out());
    #3;
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic do_reset(string nm);
    exp_t r;
    Reset = 1'b0;
    #1;
    r = '{1'b0, 1'b0, 3'd3, 16'd0, 3'd0, 1'b0, 1'b0};
    check(nm, r);
    q.delete();
    model_reset();
    #2;
    Reset = 1'b1;
  endtask

  task automatic set_car(int i, int x, int y);
    CarX[11*i +: 11] = 11'(x); CarY[11*i +: 11] = 11'(y);
  endtask

  task automatic set_log(int i, int x, int y);
    LogX[11*i +: 11] = 11'(x); LogY[11*i +: 11] = 11'(y);
  endtask

  task automatic scene_clear();
    for (int i = 0; i < NC; i++) set_car(i, 100 * i, 700);
    for (int i = 0; i < NL; i++) set_log(i, 100 * i, 700);
  endtask

  task automatic frog(int x, int y);
    FrogX = 11'(x); FrogY = 11'(y);
  endtask

  initial begin
    Frog_Width = 11'd40; Frog_Height = 11'd40;
    Car_Width = 11'd40; Car_Height = 11'd40;
    Log_Width = 11'd120; Log_Height = 11'd40;
    scene_clear();
    frog(320, 440);
    model_reset();
    #8;
    do_reset("reset_init");

    // Forward progress scores once per new best row.
    frames(2);
    frog(320, 400); frame();
    frog(320, 360); frame();
    frog(320, 400); frames(2);

    // Edge-touching car is harmless; overlapping car kills.
    set_car(0, 360, 400); frames(2);
    set_car(0, 330, 400); frames(10);
    set_car(0, 360, 400); frames(28);

    // Water row: log carries the frog, invalid frame is ignored.
    set_log(0, 300, 120); frog(320, 120); frames(3);
    frog(320, 2040); frames(2);
    frog(320, 120); set_log(0, 0, 700); frames(36);

    // Five homes, each with a car overlapping the home frame.
    set_car(1, 320, 0);
    for (int h = 0; h < 5; h++) begin
      frog(320, 0); frame();
      frog(320, 440); frames(3);
    end

    // Last life: game over is sticky.
    set_car(0, 330, 400); frog(320, 400); frames(40);
    frog(320, 0); frames(3);

    // Reset in the middle of a death sequence.
    do_reset("reset_after_over");
    frog(320, 400); frames(8);
    do_reset("reset_mid_dying");
    scene_clear(); frog(320, 440); frames(2);

    // Randomized play in blocks, reset between blocks.
    for (int b = 0; b < 8; b++) begin
      do_reset("reset_block");
      for (int f = 0; f < 80; f++) begin
        for (int i = 0; i < NC; i++) set_car(i, $urandom_range(0, 600), 40 * $urandom_range(6, 10));
        for (int i = 0; i < NL; i++) set_log(i, $urandom_range(0, 600), 40 * $urandom_range(1, 4));
        if ($urandom_range(0, 15) == 0) frog($urandom_range(0, 2047), $urandom_range(800, 2047));
        else frog($urandom_range(200, 440), 40 * $urandom_range(0, 11));
        frame();
      end
    end

    @(posedge frame_clk); #3;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frog_status.md
# frog_status

Hazard, scoring and lives controller downstream of the frog mover. Each frame it compares the frog's bounding box against car and log boxes and the home row. It drives a death/respawn sequence back into the frog mover's reset, and holds lives, score and home count for the HUD. All outputs are registered on frame_clk.

## Interface
Parameters:
- NUM_CARS, 4, number of car boxes
- NUM_LOGS, 4, number of log boxes
- LIVES_INIT, 3, lives loaded at reset (1..7)
- DEATH_FRAMES, 30, frames Dying stays high (≥1)
- FROG_Y_START, 440, best-row value after reset/respawn
- HOME_Y, 0, frog Y that counts as reaching home
- WATER_Y_MIN, 40, first water row Y (inclusive)
- WATER_Y_MAX, 200, water region end Y (exclusive)

Ports (clock and reset first):
- frame_clk  in  1  frame-rate clock (vsync)
- Reset  in  1  asynchronous, active-low reset
- FrogX, FrogY  in  11 each  frog top-left position
- Frog_Width, Frog_Height  in  11 each  frog size
- CarX, CarY  in  11*NUM_CARS each  packed car top-left positions; car i at [11*i+10:11*i]
- Car_Width, Car_Height  in  11 each  common car size
- LogX, LogY  in  11*NUM_LOGS each  packed log positions, same packing as cars
- Log_Width, Log_Height  in  11 each  common log size
- Frog_Respawn  out  1  active-high; ORed into the frog mover's reset
- Dying  out  1  high during the death animation
- Lives  out  3  remaining lives
- Score  out  16  binary, saturates at 16'hFFFF
- Homes  out  3  homes reached this level (0..4)
- Level_Up  out  1  one-frame pulse on the fifth home
- Game_Over  out  1  sticky until reset

## Operation
- Overlap test for box A vs box B: A.x < B.x+B.w AND B.x < A.x+A.w, and the same for y. Sums are computed at 12 bits, so there is no wrap. Inequalities are strict, so boxes that only touch edges do not overlap.
- FrogX ≥ 800 or FrogY ≥ 800 is an invalid frame (transient underflow from the mover). On an invalid frame, no hazard, home or score evaluation happens, and state is held.
- car_hit = frog overlaps any car.
- water_hit = FROG_Y in [WATER_Y_MIN, WATER_Y_MAX) AND frog overlaps no log.
- at_home = FrogY == HOME_Y.
- FSM states:
  - ALIVE
    - at_home → HOME. Home has priority over any simultaneous hit.
    - Otherwise car_hit or water_hit → DYING, with counter ← DEATH_FRAMES-1.
    - Otherwise, if FrogY < Best_Y: Best_Y ← FrogY and Score += 10 (saturating).
  - DYING
    - Dying = 1; counter decrements each frame.
    - At counter == 0: if Lives == 1, then Lives ← 0 and go to OVER; else Lives ← Lives-1 and go to RESPAWN.
  - HOME
    - Entered for exactly 1 frame. On entry: Score += 50 (saturating).
    - If Homes == 4: Homes ← 0 and Level_Up = 1 for this frame; else Homes += 1.
    - Next state: RESPAWN.
  - RESPAWN
    - Frog_Respawn = 1 for 2 frames; Best_Y ← FROG_Y_START.
    - Then ALIVE. The second frame lets the mover settle; no evaluation is done in it.
  - OVER
    - Game_Over = 1, Dying = 0. All inputs are ignored until Reset.
- Score saturates: any add that would exceed 65535 yields 65535.

## Timing
- Reset asserted (low) forces, immediately and asynchronously:
  - state = ALIVE, Best_Y = FROG_Y_START, counter = 0
  - Lives = LIVES_INIT, Score = 0, Homes = 0
  - Frog_Respawn = 0, Dying = 0, Level_Up = 0, Game_Over = 0
- Reset mid-sequence (DYING, HOME, RESPAWN, OVER) behaves the same way; no pending decrement or score is applied.
- Latency: inputs are sampled at edge k; Dying, Score and Homes reflect the result after edge k (1 frame).
- Dying is high for exactly DEATH_FRAMES frames. The Lives decrement and the first Frog_Respawn frame appear together at the edge after the last Dying frame.
- Level_Up is high for exactly 1 frame, the HOME frame.
- A hazard present during DYING, HOME or RESPAWN is ignored.

## Test plan
- Reset low then high → Lives=3, Score=0, Homes=0, all flags 0; state ALIVE.
- Frog (320,400) 40x40, car (330,400) 40x40 → Dying=1 one frame later, held 30 frames; then Lives=2, Frog_Respawn high 2 frames, then ALIVE. Car at (360,400) (edge touch) → no death.
- FrogY 440→400→360→400 with no hazards → Score 10, 20, 20 (revisiting a row does not score).
- FrogY=120, no log overlap → death. Log at (300,120) 120x40 overlapping the frog → no death. FrogY=2040 (invalid) → no action.
- FrogY=0 with an overlapping car in the same frame → HOME: Score+50, Homes=1, no Dying. Five homes → Level_Up pulse on the fifth, Homes=0.
- Lives=1 and car hit → after 30 frames Lives=0 and Game_Over=1, sticky through further hits. Reset pulled low during DYING → outputs return to reset values immediately.
